// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter: sole write driver of the GRF; merges pipeline results with queued aux results.
// Optional WB_TRACE_EN prints one golden-trace line per issued write.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_wa,
  input  logic [31:0]              pipe_wd,
  input  logic [31:0]              pipe_pc,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [4:0]               aux_wa,
  input  logic [31:0]              aux_wd,
  input  logic [31:0]              aux_pc,
  output logic                     grf_we,
  output logic [4:0]               grf_wa,
  output logic [31:0]              grf_wd,
  output logic [31:0]              grf_wpc,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    q_wa [DEPTH];
  logic [31:0]   q_wd [DEPTH];
  logic [31:0]   q_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, idx;

  logic        pipe_fire, aux_fire, pop, bypass, push, issue;
  logic [4:0]  iss_wa;
  logic [31:0] iss_wd, iss_pc;

  // Ready depends only on the registered count: no pass-through when full.
  assign aux_ready = !reset && (fifo_count < CW'(DEPTH));
  assign pipe_fire = pipe_we && (pipe_wa != '0);
  assign aux_fire  = aux_valid && aux_ready && (aux_wa != '0);

  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    iss_wa = pipe_wa;
    iss_wd = pipe_wd;
    iss_pc = pipe_pc;
    if (pipe_fire) begin
      iss_wa = pipe_wa;
    end else if (fifo_count != '0) begin
      pop    = 1'b1;
      iss_wa = q_wa[rd_ptr];
      iss_wd = q_wd[rd_ptr];
      iss_pc = q_pc[rd_ptr];
    end else if (aux_fire) begin
      bypass = 1'b1;
      iss_wa = aux_wa;
      iss_wd = aux_wd;
      iss_pc = aux_pc;
    end
  end

  assign issue = pipe_fire || pop || bypass;
  assign push  = aux_fire && !bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grf_we     <= 1'b0;
      grf_wa     <= '0;
      grf_wd     <= '0;
      grf_wpc    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      grf_we <= issue;
      if (issue) begin
        grf_wa  <= iss_wa;
        grf_wd  <= iss_wd;
        grf_wpc <= iss_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone qualifies entries.
  always_ff @(posedge clk) begin
    if (push) begin
      q_wa[wr_ptr] <= aux_wa;
      q_wd[wr_ptr] <= aux_wd;
      q_pc[wr_ptr] <= aux_pc;
    end
  end

  always_comb begin
    pending_mask = '0;
    idx          = rd_ptr;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (i < 32'(fifo_count)) pending_mask[q_wa[idx]] = 1'b1;
    end
    if (grf_we) pending_mask[grf_wa] = 1'b1;
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && issue) $display("@%08h: $%02d <= %08h", iss_pc, iss_wa, iss_wd);
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_grf_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we, aux_valid, aux_ready, grf_we;
  logic [4:0]  pipe_wa, aux_wa, grf_wa;
  logic [31:0] pipe_wd, pipe_pc, aux_wd, aux_pc, grf_wd, grf_wpc, pending_mask;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_pc;

  grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_wa(aux_wa), .aux_wd(aux_wd), .aux_pc(aux_pc),
    .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd), .grf_wpc(grf_wpc),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic set_in(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd, input logic [31:0] ppc,
                        input logic av, input logic [4:0] awa, input logic [31:0] awd, input logic [31:0] apc);
    pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd; pipe_pc = ppc;
    aux_valid = av; aux_wa = awa; aux_wd = awd; aux_pc = apc;
  endtask

  task automatic model_clear();
    mq.delete();
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_pc = '0;
  endtask

  // One clock: check ready, advance the model by the issue rules, then check registered outputs.
  task automatic cycle(input string tag);
    logic        m_ready, pf, af;
    logic [31:0] exp_mask;
    ent_t        e;
    #1;
    m_ready = (mq.size() < DEPTH);
    chk(tag, "aux_ready", 32'(aux_ready), 32'(m_ready));
    pf = pipe_we && (pipe_wa != 0);
    af = aux_valid && m_ready && (aux_wa != 0);
    if (pf) begin
      m_we = 1'b1; m_wa = pipe_wa; m_wd = pipe_wd; m_pc = pipe_pc;
      if (af) mq.push_back('{aux_wa, aux_wd, aux_pc});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_wa = e.wa; m_wd = e.wd; m_pc = e.pc;
      if (af) mq.push_back('{aux_wa, aux_wd, aux_pc});
    end else if (af) begin
      m_we = 1'b1; m_wa = aux_wa; m_wd = aux_wd; m_pc = aux_pc;
    end else begin
      m_we = 1'b0;
    end
    exp_mask = '0;
    foreach (mq[i]) exp_mask[mq[i].wa] = 1'b1;
    if (m_we) exp_mask[m_wa] = 1'b1;
    @(posedge clk);
    #1;
    chk(tag, "grf_we", 32'(grf_we), 32'(m_we));
    chk(tag, "grf_wa", 32'(grf_wa), 32'(m_wa));
    chk(tag, "grf_wd", grf_wd, m_wd);
    chk(tag, "grf_wpc", grf_wpc, m_pc);
    chk(tag, "fifo_count", 32'(fifo_count), mq.size());
    chk(tag, "pending_mask", pending_mask, exp_mask);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk);
    #1;
    chk("rst", "grf_we", 32'(grf_we), 0);
    chk("rst", "grf_wa", 32'(grf_wa), 0);
    chk("rst", "grf_wd", grf_wd, 0);
    chk("rst", "grf_wpc", grf_wpc, 0);
    chk("rst", "fifo_count", 32'(fifo_count), 0);
    chk("rst", "pending_mask", pending_mask, 0);
    chk("rst", "aux_ready", 32'(aux_ready), 0);
    @(negedge clk);
    reset = 1'b0;

    // Pipe-only write
    set_in(1, 5, 32'h12345678, 32'h3000, 0, 0, 0, 0);
    cycle("pipe");
    chk("pipe", "we_k", 32'(grf_we), 1);
    chk("pipe", "wa_k", 32'(grf_wa), 5);
    chk("pipe", "wd_k", grf_wd, 32'h12345678);
    chk("pipe", "wpc_k", grf_wpc, 32'h3000);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("pipe_idle");

    // Bypass
    set_in(0, 0, 0, 0, 1, 8, 32'hAA, 32'h4000);
    cycle("byp");
    chk("byp", "wa_k", 32'(grf_wa), 8);
    chk("byp", "count_k", 32'(fifo_count), 0);
    chk("byp", "mask_k", pending_mask, 32'h100);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("byp_idle");
    chk("byp_idle", "mask_k", pending_mask, 0);

    // Contention
    set_in(1, 3, 32'h33, 32'h100, 1, 9, 32'h99, 32'h200);
    cycle("cont");
    chk("cont", "wa_k", 32'(grf_wa), 3);
    chk("cont", "count_k", 32'(fifo_count), 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("cont2");
    chk("cont2", "wa_k", 32'(grf_wa), 9);
    chk("cont2", "wd_k", grf_wd, 32'h99);

    // Full backpressure
    for (int k = 1; k <= 4; k++) begin
      set_in(1, 1, 32'h1000 + k, 32'h5000 + k, 1, 5'(k), 32'hB0 + k, 32'h6000 + k);
      cycle("full");
    end
    chk("full", "count_k", 32'(fifo_count), 4);
    chk("full", "mask_k", pending_mask, 32'h1E);
    chk("full", "ready_k", 32'(aux_ready), 0);
    set_in(1, 1, 32'h2000, 32'h7000, 1, 5, 32'h55, 32'h7100);
    cycle("full_hold");
    chk("full_hold", "count_k", 32'(fifo_count), 4);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle("drain");
      chk("drain", "we_k", 32'(grf_we), 1);
      chk("drain", "wa_k", 32'(grf_wa), k);
      if (k == 1) chk("drain", "ready_k", 32'(aux_ready), 1);
    end

    // $0 filter
    set_in(1, 0, 32'hDEAD, 32'h10, 1, 0, 32'hBEEF, 32'h20);
    cycle("zero");
    chk("zero", "we_k", 32'(grf_we), 0);
    chk("zero", "count_k", 32'(fifo_count), 0);

    // Reset mid-run with 3 entries queued
    for (int k = 0; k < 3; k++) begin
      set_in(1, 2, 32'h700 + k, 32'h8000 + k, 1, 5'(6 + k), 32'h900 + k, 32'h9000 + k);
      cycle("prerst");
    end
    chk("prerst", "count_k", 32'(fifo_count), 3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst", "count_k", 32'(fifo_count), 0);
    chk("midrst", "mask_k", pending_mask, 0);
    chk("midrst", "ready_k", 32'(aux_ready), 0);
    chk("midrst", "we_k", 32'(grf_we), 0);
    @(posedge clk);
    #1;
    chk("midrst2", "we_k", 32'(grf_we), 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    cycle("postrst");
    chk("postrst", "we_k", 32'(grf_we), 0);

    // Random traffic: pipe-heavy phase fills the FIFO, light phase drains it
    for (int n = 0; n < 400; n++) begin
      int unsigned ppct;
      ppct = (n < 200) ? 70 : 25;
      set_in($urandom_range(0, 99) < ppct, 5'($urandom_range(0, 31)), $urandom, $urandom,
             $urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom, $urandom);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
